// File: rtl/keycode_report_decoder.sv
// Streams 8-byte HID boot-keyboard reports and tracks held W/S/A/D keys.
// Emits the most recently pressed still-held direction keycode and counts malformed reports.
module keycode_report_decoder #(
    parameter int unsigned NUM_KEYCODE_BYTES = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       rpt_valid,
    output logic       rpt_ready,
    input  logic [7:0] rpt_byte,
    input  logic       rpt_last,
    output logic [7:0] key,
    output logic       key_strobe,
    output logic [7:0] err_count
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MASK_W = 4;

    localparam logic [IDX_W-1:0]  FIRST_KC_IDX = IDX_W'(2);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_KEYCODE_BYTES + 1);
    localparam logic [BYTE_W-1:0] KC_ROLLOVER  = BYTE_W'(8'h01);
    localparam logic [BYTE_W-1:0] KC_NONE      = BYTE_W'(8'h00);
    localparam logic [BYTE_W-1:0] ERR_MAX      = BYTE_W'(8'hFF);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_SKIP    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MASK_W-1:0]   cur_mask_q, cur_mask_d;
    logic [MASK_W-1:0]   prev_mask_q, prev_mask_d;
    logic [BYTE_W-1:0]   cand_q, cand_d;
    logic                cand_vld_q, cand_vld_d;
    logic [BYTE_W-1:0]   held_q, held_d;
    logic                held_vld_q, held_vld_d;
    logic                roll_q, roll_d;
    logic [BYTE_W-1:0]   key_q, key_d;
    logic                strobe_q, strobe_d;
    logic                ready_q, ready_d;
    logic [BYTE_W-1:0]   err_q, err_d;

    // Direction keycode to mask bit: up, down, left, right.
    function automatic logic [MASK_W-1:0] dir_onehot(input logic [BYTE_W-1:0] kc);
        logic [MASK_W-1:0] oh;
        oh = '0;
        case (kc)
            8'h1a:   oh = MASK_W'(4'b0001);
            8'h16:   oh = MASK_W'(4'b0010);
            8'h04:   oh = MASK_W'(4'b0100);
            8'h07:   oh = MASK_W'(4'b1000);
            default: oh = '0;
        endcase
        return oh;
    endfunction

    logic [MASK_W-1:0] byte_oh;
    logic [MASK_W-1:0] key_oh;
    logic              accept;
    logic              in_kc;
    logic              clear_rpt;
    logic              bump_err;

    assign byte_oh = dir_onehot(rpt_byte);
    assign key_oh  = dir_onehot(key_q);
    assign accept  = rpt_valid && ready_q;
    assign in_kc   = (idx_q >= FIRST_KC_IDX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            cur_mask_q  <= '0;
            prev_mask_q <= '0;
            cand_q      <= '0;
            cand_vld_q  <= 1'b0;
            held_q      <= '0;
            held_vld_q  <= 1'b0;
            roll_q      <= 1'b1;
            key_q       <= KC_NONE;
            strobe_q    <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_mask_q  <= cur_mask_d;
            prev_mask_q <= prev_mask_d;
            cand_q      <= cand_d;
            cand_vld_q  <= cand_vld_d;
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
            roll_q      <= roll_d;
            key_q       <= key_d;
            strobe_q    <= strobe_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_mask_d  = cur_mask_q;
        prev_mask_d = prev_mask_q;
        cand_d      = cand_q;
        cand_vld_d  = cand_vld_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        roll_d      = roll_q;
        key_d       = key_q;
        err_d       = err_q;
        clear_rpt   = 1'b0;
        bump_err    = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (in_kc) begin
                        if (byte_oh != '0) begin
                            cur_mask_d = cur_mask_q | byte_oh;
                            held_d     = rpt_byte;
                            held_vld_d = 1'b1;
                            if ((prev_mask_q & byte_oh) == '0) begin
                                cand_d     = rpt_byte;
                                cand_vld_d = 1'b1;
                            end
                        end
                        if (rpt_byte != KC_ROLLOVER) begin
                            roll_d = 1'b0;
                        end
                    end
                    if (rpt_last) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_COMMIT;
                        end else begin
                            bump_err  = 1'b1;
                            clear_rpt = 1'b1;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        bump_err  = 1'b1;
                        clear_rpt = 1'b1;
                        state_d   = ST_SKIP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SKIP: begin
                if (accept && rpt_last) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COMMIT: begin
                // A phantom-state (all 0x01) report leaves the key history untouched.
                if (!roll_q) begin
                    if (cand_vld_q) begin
                        key_d = cand_q;
                    end else if ((key_q != KC_NONE) && ((cur_mask_q & key_oh) != '0)) begin
                        key_d = key_q;
                    end else if (held_vld_q) begin
                        key_d = held_q;
                    end else begin
                        key_d = KC_NONE;
                    end
                    prev_mask_d = cur_mask_q;
                end
                clear_rpt = 1'b1;
                state_d   = ST_COLLECT;
            end
            default: begin
                clear_rpt = 1'b1;
                state_d   = ST_COLLECT;
            end
        endcase

        if (bump_err && (err_q != ERR_MAX)) begin
            err_d = err_q + BYTE_W'(1);
        end

        if (clear_rpt) begin
            idx_d      = '0;
            cur_mask_d = '0;
            cand_d     = '0;
            cand_vld_d = 1'b0;
            held_d     = '0;
            held_vld_d = 1'b0;
            roll_d     = 1'b1;
        end

        strobe_d = (key_d != key_q);
        ready_d  = (state_d != ST_COMMIT);
    end

    assign key        = key_q;
    assign key_strobe = strobe_q;
    assign rpt_ready  = ready_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_keycode_report_decoder.sv
// Bench for keycode_report_decoder: directed report table, reset corner cases,
// and randomized reports checked against a whole-report reference model.
module tb_keycode_report_decoder;

    logic       Clk;
    logic       Reset_n;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [7:0] rpt_byte;
    logic       rpt_last;
    logic [7:0] key;
    logic       key_strobe;
    logic [7:0] err_count;

    keycode_report_decoder #(.NUM_KEYCODE_BYTES(6)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_byte   (rpt_byte),
        .rpt_last   (rpt_last),
        .key        (key),
        .key_strobe (key_strobe),
        .err_count  (err_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [47:0] kc;
        int          n;
        logic [7:0]  exp_key;
        logic [7:0]  exp_err;
    } vec_t;

    typedef logic [7:0] rpt_t [12];

    int checks = 0;
    int errors = 0;
    int strobe_seen = 0;
    int strobe_exp = 0;

    // Reference state: current key, set of keys held in last committed report, error count.
    logic [7:0] m_key;
    bit         m_held [4];
    int         m_err;

    always @(posedge Clk) begin
        if (Reset_n && key_strobe) strobe_seen++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dir_pos(input logic [7:0] kc);
        case (kc)
            8'h1a:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_key = 8'h00;
        m_err = 0;
        foreach (m_held[i]) m_held[i] = 1'b0;
    endtask

    // Whole-report evaluation: newest newly-pressed key wins, else keep a still-held key,
    // else fall back to the last-listed held key.
    task automatic model_commit(input rpt_t b, output bit changed);
        bit         all_roll;
        bit         now [4];
        logic [7:0] newest_new;
        logic [7:0] newest_held;
        logic [7:0] nk;
        all_roll = 1'b1;
        for (int p = 2; p < 8; p++) if (b[p] != 8'h01) all_roll = 1'b0;
        changed = 1'b0;
        if (all_roll) return;
        foreach (now[i]) now[i] = 1'b0;
        newest_new  = 8'h00;
        newest_held = 8'h00;
        for (int p = 2; p < 8; p++) begin
            int d;
            d = dir_pos(b[p]);
            if (d >= 0) begin
                now[d] = 1'b1;
                newest_held = b[p];
                if (!m_held[d]) newest_new = b[p];
            end
        end
        if (newest_new != 8'h00)                             nk = newest_new;
        else if (m_key != 8'h00 && now[dir_pos(m_key)])      nk = m_key;
        else                                                 nk = newest_held;
        changed = (nk != m_key);
        if (changed) strobe_exp++;
        m_key = nk;
        foreach (m_held[i]) m_held[i] = now[i];
    endtask

    task automatic idle_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Called 1ns after an edge; returns 1ns after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input logic l);
        int waitc;
        waitc = 0;
        rpt_valid = 1'b1;
        rpt_byte  = b;
        rpt_last  = l;
        while (!rpt_ready && waitc < 20) begin
            idle_cycle();
            waitc++;
        end
        if (!rpt_ready) begin
            chk("ready_timeout", 32'(rpt_ready), 32'd1);
        end else begin
            idle_cycle();
        end
        rpt_valid = 1'b0;
        rpt_byte  = 8'($urandom);
        rpt_last  = 1'($urandom);
    endtask

    task automatic send_rpt(input rpt_t b, input int n, input bit gaps);
        bit changed;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            send_byte(b[i], (i == n - 1));
        end
        if (n == 8) begin
            model_commit(b, changed);
            chk("commit_ready_low", 32'(rpt_ready), 32'd0);
            chk("commit_strobe_low", 32'(key_strobe), 32'd0);
            idle_cycle();
            chk("key", 32'(key), 32'(m_key));
            chk("key_strobe", 32'(key_strobe), 32'(changed));
            chk("ready_back", 32'(rpt_ready), 32'd1);
            chk("err_count", 32'(err_count), 32'(m_err));
        end else begin
            if (m_err < 255) m_err++;
            chk("bad_err_count", 32'(err_count), 32'(m_err));
            chk("bad_key_hold", 32'(key), 32'(m_key));
            chk("bad_ready", 32'(rpt_ready), 32'd1);
        end
    endtask

    function automatic rpt_t build(input logic [47:0] kc);
        rpt_t r;
        foreach (r[i]) r[i] = 8'h00;
        for (int k = 0; k < 6; k++) r[2 + k] = kc[47 - 8 * k -: 8];
        return r;
    endfunction

    function automatic logic [7:0] rand_kc();
        case ($urandom_range(0, 6))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h1a;
            3:       return 8'h16;
            4:       return 8'h04;
            5:       return 8'h07;
            default: return 8'($urandom);
        endcase
    endfunction

    vec_t tv [17];

    initial begin
        rpt_t r;
        tv[0]  = '{48'h1a0000000000, 8,  8'h1a, 8'd0};
        tv[1]  = '{48'h1a0700000000, 8,  8'h07, 8'd0};
        tv[2]  = '{48'h1a0000000000, 8,  8'h1a, 8'd0};
        tv[3]  = '{48'h000000000000, 8,  8'h00, 8'd0};
        tv[4]  = '{48'h1a0000000000, 8,  8'h1a, 8'd0};
        tv[5]  = '{48'h1a0000000000, 8,  8'h1a, 8'd0};
        tv[6]  = '{48'h160000000000, 8,  8'h16, 8'd0};
        tv[7]  = '{48'h010101010101, 8,  8'h16, 8'd0};
        tv[8]  = '{48'h160000000000, 8,  8'h16, 8'd0};
        tv[9]  = '{48'h010101010101, 8,  8'h16, 8'd0};
        tv[10] = '{48'h041600000000, 8,  8'h04, 8'd0};
        tv[11] = '{48'h070000000000, 4,  8'h04, 8'd1};
        tv[12] = '{48'h070000000000, 10, 8'h04, 8'd2};
        tv[13] = '{48'h071600000000, 8,  8'h07, 8'd2};
        tv[14] = '{48'h041a1607071a, 8,  8'h1a, 8'd2};
        tv[15] = '{48'h070707000000, 8,  8'h07, 8'd2};
        tv[16] = '{48'h000000000000, 8,  8'h00, 8'd2};

        Reset_n   = 1'b0;
        rpt_valid = 1'b0;
        rpt_byte  = 8'h00;
        rpt_last  = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_key", 32'(key), 32'h00);
        chk("rst_strobe", 32'(key_strobe), 32'd0);
        chk("rst_ready", 32'(rpt_ready), 32'd1);
        chk("rst_err", 32'(err_count), 32'd0);
        Reset_n = 1'b1;
        idle_cycle();

        for (int i = 0; i < 17; i++) begin
            send_rpt(build(tv[i].kc), tv[i].n, 1'b0);
            chk($sformatf("tv%0d_key", i), 32'(key), 32'(tv[i].exp_key));
            chk($sformatf("tv%0d_err", i), 32'(err_count), 32'(tv[i].exp_err));
        end

        // Mid-report asynchronous reset after five bytes, with a non-zero key standing.
        send_rpt(build(48'h160000000000), 8, 1'b0);
        r = build(48'h1a0400000000);
        for (int i = 0; i < 5; i++) send_byte(r[i], 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_key", 32'(key), 32'h00);
        chk("midrst_strobe", 32'(key_strobe), 32'd0);
        chk("midrst_ready", 32'(rpt_ready), 32'd1);
        chk("midrst_err", 32'(err_count), 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle_cycle();
        send_rpt(build(48'h000004000000), 8, 1'b0);
        chk("post_rst_key", 32'(key), 32'h04);

        // Randomized reports, including short, overlong and rollover ones, with valid gaps.
        for (int t = 0; t < 200; t++) begin
            int n;
            int sel;
            sel = int'($urandom_range(0, 9));
            foreach (r[i]) r[i] = rand_kc();
            r[0] = 8'($urandom);
            r[1] = 8'($urandom);
            if (sel == 0)      n = int'($urandom_range(1, 7));
            else if (sel == 1) n = int'($urandom_range(9, 12));
            else               n = 8;
            if (sel == 2) for (int p = 2; p < 8; p++) r[p] = 8'h01;
            send_rpt(r, n, 1'b1);
        end

        repeat (2) idle_cycle();
        chk("strobe_total", 32'(strobe_seen), 32'(strobe_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keycode_report_decoder.md
# keycode_report_decoder

Parses 8-byte USB HID boot-keyboard reports, streamed one byte at a time from the USB/NIOS side, into the single 8-bit direction keycode consumed by the ball motion logic. It tracks which of the four direction keys (W/S/A/D) are held across reports. It outputs the most recently pressed key that is still held, or 0x00 when none are held. It also flags malformed reports.

## Interface
- NUM_KEYCODE_BYTES, 6: keycode bytes per report, at report bytes 2..7. Byte 0 is the modifier byte and byte 1 is reserved; both are ignored.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- rpt_valid  in  1  rpt_byte is valid this cycle.
- rpt_ready  out  1  decoder accepts a byte. A byte transfers on a cycle where rpt_valid and rpt_ready are both 1.
- rpt_byte  in  8  report byte.
- rpt_last  in  1  marks the final byte of a report.
- key  out  8  current direction keycode: 0x1a (up), 0x16 (down), 0x04 (left), 0x07 (right), or 0x00 (none held).
- key_strobe  out  1  one-cycle pulse when key changes value.
- err_count  out  8  saturating count of malformed reports.

## Operation
- Direction mask bit order: bit0 = 0x1a, bit1 = 0x16, bit2 = 0x04, bit3 = 0x07. All other keycodes are ignored.
- Registers:
  - byte index idx, 3 bits.
  - cur_mask, 4 bits.
  - prev_mask, 4 bits.
  - cand: the latest-position newly-pressed key, 8 bits plus a valid bit.
  - held_last: the latest-position held direction key, 8 bits plus a valid bit.
  - rollover flag.
- States: COLLECT, COMMIT, SKIP.
- COLLECT (rpt_ready = 1), on each accepted byte:
  - At idx 2..7, if the byte is a direction key: set its bit in cur_mask and load held_last with it.
  - If its bit is also clear in prev_mask, load cand with it. Later positions overwrite earlier ones.
  - At idx 2..7, clear the rollover flag if the byte is not 0x01.
  - If rpt_last = 1 and idx = 7: go to COMMIT.
  - If rpt_last = 1 and idx ≠ 7: malformed. Increment err_count, clear the per-report registers, set idx = 0, stay in COLLECT.
  - If rpt_last = 0 and idx = 7: malformed. Increment err_count, go to SKIP.
  - Otherwise, idx increments.
- SKIP (rpt_ready = 1): discard accepted bytes until one arrives with rpt_last = 1, then return to COLLECT with idx = 0. Per-report registers are cleared on entry to SKIP.
- COMMIT (rpt_ready = 0, lasts exactly one cycle):
  - If the rollover flag is set (bytes 2..7 were all 0x01): no change to key or prev_mask.
  - Else if cand is valid: key ← cand.
  - Else if key ≠ 0x00 and key's bit is still set in cur_mask: key unchanged.
  - Else if held_last is valid: key ← held_last.
  - Else: key ← 0x00.
  - Unless rollover: prev_mask ← cur_mask.
  - Always: clear the per-report registers, set idx = 0, set rollover flag = 1 for the next report, return to COLLECT.
- A direction key repeated within one report is idempotent.
- err_count saturates at 0xFF.

## Timing
- Reset values:
  - key = 0x00, key_strobe = 0, rpt_ready = 1, err_count = 0x00.
  - prev_mask = 0, idx = 0, state = COLLECT, rollover flag = 1.
- Reset takes effect immediately, asynchronously, including mid-report. The partial report is lost.
- Latency: if the final byte is accepted in cycle N:
  - Cycle N+1 is COMMIT, with rpt_ready = 0.
  - key takes its new value from cycle N+2.
  - key_strobe is 1 only in cycle N+2, and only if key changed.
  - rpt_ready returns to 1 in cycle N+2.
- Back-to-back reports sustain one byte per cycle, except for the single COMMIT bubble.
- rpt_byte and rpt_last are sampled only on accept cycles. Sources must hold them stable while rpt_valid = 1 and rpt_ready = 0.
- err_count updates in the cycle after the offending byte is accepted.

## Test plan
- Reset, then report 00 00 1a 00 00 00 00 00 -> key = 0x1a two cycles after the last byte, key_strobe pulses once, rpt_ready low for exactly one cycle.
- Follow with 00 00 1a 07 00 00 00 00 -> key = 0x07. Then 00 00 1a 00 00 00 00 00 -> key = 0x1a, because up is still held. Then an all-zero report -> key = 0x00. Each change produces one strobe.
- Repeat the same report (1a only) twice -> second commit causes no key change and no strobe.
- Report 00 00 01 01 01 01 01 01 while key = 0x16 -> key stays 0x16 and prev_mask is unchanged. A following report with 16 still held produces no strobe.
- Malformed reports:
  - rpt_last on byte 3 -> err_count = 1, key unchanged.
  - 10 bytes with rpt_last only on the 10th -> err_count = 2, bytes dropped in SKIP.
  - Next well-formed report decodes correctly.
- Assert Reset_n low mid-report (after byte 4) -> all outputs return to reset values immediately. A fresh report then decodes normally.
